// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_bit.sv
// Single-bit full adder cell, time-shared by the serial controller.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic Cout
);

    // Plain sum/majority equations.
    always_comb begin
        sum  = a ^ b ^ c;
        Cout = (a & b) | (a & c) | (b & c);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first over
// WIDTH cycles through one shared fa_bit cell, with start/busy/done handshake.
// Optional build macro SERIAL_ADD_SUB_EN adds a 'sub' input for a-b.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_a, sh_b, res_sh, res_nxt;
    logic [WIDTH-1:0] b_ld;
    logic             c_ld;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_c;
    logic             last_bit;

    fa_bit u_fa (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .c    (carry),
        .sum  (fa_s),
        .Cout (fa_c)
    );

    // Operand B / carry-in selection at capture; subtraction is a + ~b + 1.
    always_comb begin
`ifdef SERIAL_ADD_SUB_EN
        b_ld = sub ? ~b : b;
        c_ld = sub ? 1'b1 : cin;
`else
        b_ld = b;
        c_ld = cin;
`endif
    end

    // Next result word and end-of-operand detect.
    always_comb begin
        res_nxt  = {fa_s, res_sh[WIDTH-1:1]};
        last_bit = (cnt == LAST);
    end

    // Next-state logic: one IDLE cycle always separates operations.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, operand shifters, carry feedback and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b_ld;
                        carry <= c_ld;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sh_a   <= sh_a >> 1;
                    sh_b   <= sh_b >> 1;
                    res_sh <= res_nxt;
                    carry  <= fa_c;
                    if (last_bit) begin
                        // Publish on the edge entering DONE so sum is valid with done.
                        cnt  <= '0;
                        sum  <= res_nxt;
                        cout <= fa_c;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller. It time-shares one single-bit full-adder cell to add two WIDTH-bit operands, LSB first, over WIDTH cycles. It owns operand capture, carry feedback, bit sequencing and the start/busy/done handshake, and sits between a requester and the shared full-adder datapath.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepted start
b  input  WIDTH  operand B; captured on the accepted start
cin  input  1  carry-in; captured on the accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when the result is valid
sum  output  WIDTH  result register; holds until the next result
cout  output  1  final carry-out; holds with sum

Behaviour:
- Reset: rst=1 at a clk edge forces state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, and clears the shift registers. Reset applies from any state, including mid-operation.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1. On that edge, capture a and b into shift registers, load the carry flop with cin, and set counter=0.
  - RUN: each cycle, the cell takes the LSB of shA, the LSB of shB and the carry flop.
    - Cell sum bit shifts into the MSB of the result shift register; cell carry loads the carry flop.
    - shA and shB shift right; counter increments.
    - RUN -> DONE when counter==WIDTH-1 on that edge, i.e. after exactly WIDTH bit-cycles.
  - DONE: lasts exactly one cycle. Result shift register copies into sum, carry flop copies into cout, done=1. Then DONE -> IDLE unconditionally.
- Latency: start accepted at edge 0 gives busy=1 for cycles 1..WIDTH and done=1 in cycle WIDTH+1. sum/cout update at the same edge that raises done.
- busy is 1 only in RUN; done is 1 only in DONE; they are never high together.
- start in RUN or DONE is ignored and not queued. The requester must re-assert start after done.
- start held high continuously gives back-to-back operations with one IDLE cycle between them.
- a, b and cin are don't-care except on the accepting edge.
- Arithmetic: the result is modulo 2^WIDTH; cout is the true carry out of bit WIDTH-1.
- Counter width is $clog2(WIDTH); no wrap-around occurs because RUN exits at WIDTH-1.

Optional Feature:
Macro SERIAL_ADD_SUB_EN.
- Defined:
  - Adds an input port sub (1 bit), captured with the operands.
  - When sub=1, the B shift register loads ~b and the carry flop loads 1 (cin is ignored), producing a-b.
  - cout=1 means no borrow.
- Undefined: no sub port; addition only, exactly as above.

Decomposition:
- Shared package serial_add_pkg holds:
  - state enum type: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - constant DEFAULT_WIDTH=8.
- One sub-module, fa_bit: a combinational single-bit full adder with inputs a, b, c and outputs sum, Cout.
- The controller instantiates exactly one fa_bit.

Test Plan:
- WIDTH=8: a=8'hFF, b=8'h01, cin=0, start for one cycle -> busy high 8 cycles; done in cycle 9; sum=8'h00, cout=1.
- a=8'h5A, b=8'h25, cin=1 -> sum=8'h80, cout=0. Both values then hold through 5 idle cycles with done=0.
- Start op a=8'h03, b=8'h04. Pulse start with a=8'hFF in RUN cycle 3 -> ignored; result sum=8'h07, cout=0; no second done.
- Assert rst in RUN cycle 4 -> next cycle busy=0, done=0, sum=8'h00, cout=0. A new op a=8'h10, b=8'h20 then yields 8'h30 with correct latency.
- With SERIAL_ADD_SUB_EN: sub=1, a=8'h10, b=8'h01 -> sum=8'h0F, cout=1. Then sub=1, a=8'h00, b=8'h01 -> sum=8'hFF, cout=0.
- WIDTH=2, exhaustive over all a, b and cin (32 cases), back-to-back with start held high -> {cout,sum}==a+b+cin every time; one idle cycle between each done and the next busy.
